// File: rtl/limb_pkg.sv
// Shared Limb definitions: loader states and program-memory geometry.
// Also used by the fetch path.
package limb_pkg;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_COUNT,
        LD_DATA,
        LD_CHECK
    } loader_state_t;

    localparam int LIMB_PROG_AW = 8;
    localparam int LIMB_INSN_W = 32;

    localparam logic [7:0] LIMB_LOADER_SYNC = 8'hA5;

endpackage

// File: rtl/limb_word_packer.sv
// Assembles four little-endian bytes into one instruction word.
// word_valid is combinational with the fourth byte.
module limb_word_packer
    import limb_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   word_valid,
    output logic [LIMB_INSN_W-1:0] word
);

    logic [1:0]  lane_q;
    logic [23:0] asm_q;

    assign word_valid = byte_valid && !clear && (lane_q == 2'd3);
    assign word = {byte_data, asm_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_q <= 2'd0;
            asm_q  <= 24'd0;
        end else if (clear) begin
            lane_q <= 2'd0;
        end else if (byte_valid) begin
            lane_q <= lane_q + 2'd1;
            unique case (lane_q)
                2'd0: asm_q[7:0]   <= byte_data;
                2'd1: asm_q[15:8]  <= byte_data;
                2'd2: asm_q[23:16] <= byte_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/limb_loader.sv
// Framed byte-stream loader for Limb program memory.
// Define LIMB_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum.
module limb_loader
    import limb_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = LIMB_LOADER_SYNC,
    parameter int         TIMEOUT   = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    prog_we,
    output logic [LIMB_PROG_AW-1:0] prog_addr,
    output logic [LIMB_INSN_W-1:0]  prog_data,
    output logic                    cpu_hold,
    output logic                    done,
    output logic                    error
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    loader_state_t state_q, state_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          hold_d, done_d, error_d, we_d;
    logic [LIMB_PROG_AW-1:0] addr_d;
    logic [LIMB_INSN_W-1:0]  data_d;
    logic          pack_clr, pack_in;
    logic          word_valid;
    logic [LIMB_INSN_W-1:0]  word;
`ifdef LIMB_LOADER_CHECKSUM_EN
    logic [7:0]    sum_q, sum_d;
`endif

    assign in_ready = 1'b1;
    assign pack_in  = in_valid && (state_q == LD_DATA);

    limb_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pack_clr),
        .byte_valid (pack_in),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        hold_d   = cpu_hold;
        done_d   = done;
        error_d  = error;
        we_d     = 1'b0;
        addr_d   = prog_addr;
        data_d   = prog_data;
        pack_clr = 1'b0;
`ifdef LIMB_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        if (word_valid) begin
            we_d   = 1'b1;
            addr_d = idx_q;
            data_d = word;
            idx_d  = idx_q + 8'd1;
        end
        unique case (state_q)
            LD_IDLE: begin
                if (in_valid && in_data == SYNC_BYTE) begin
                    state_d  = LD_COUNT;
                    hold_d   = 1'b1;
                    done_d   = 1'b0;
                    error_d  = 1'b0;
                    idx_d    = 8'd0;
                    pack_clr = 1'b1;
`ifdef LIMB_LOADER_CHECKSUM_EN
                    sum_d    = 8'd0;
`endif
                end
            end
            LD_COUNT: begin
                if (in_valid) begin
                    cnt_d   = in_data;
                    state_d = LD_DATA;
`ifdef LIMB_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + in_data;
`endif
                end
            end
            LD_DATA: begin
                if (in_valid) begin
`ifdef LIMB_LOADER_CHECKSUM_EN
                    sum_d = sum_q + in_data;
`endif
                    // N=0 gives cnt-1 = 255, i.e. 256 words
                    if (word_valid && idx_q == cnt_q - 8'd1) begin
`ifdef LIMB_LOADER_CHECKSUM_EN
                        state_d = LD_CHECK;
`else
                        state_d = LD_IDLE;
                        hold_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef LIMB_LOADER_CHECKSUM_EN
            LD_CHECK: begin
                if (in_valid) begin
                    state_d = LD_IDLE;
                    hold_d  = 1'b0;
                    if (in_data == sum_q) done_d = 1'b1;
                    else error_d = 1'b1;
                end
            end
`endif
            default: state_d = LD_IDLE;
        endcase
        if (state_q != LD_IDLE) begin
            if (in_valid) begin
                timer_d = '0;
            end else if (TIMEOUT != 0 && timer_q == TW'(TIMEOUT - 1)) begin
                state_d  = LD_IDLE;
                hold_d   = 1'b0;
                error_d  = 1'b1;
                pack_clr = 1'b1;
                timer_d  = '0;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end else begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= LD_IDLE;
            idx_q     <= 8'd0;
            cnt_q     <= 8'd0;
            timer_q   <= '0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            cpu_hold  <= hold_d;
            done      <= done_d;
            error     <= error_d;
            prog_we   <= we_d;
            prog_addr <= addr_d;
            prog_data <= data_d;
        end
    end

`ifdef LIMB_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sum_q <= 8'd0;
        else        sum_q <= sum_d;
    end
`endif

endmodule
